// File: rtl/qm_sweep_ctrl.sv
// Exhaustive truth-table sweep controller: walks fn_in over every minterm, counting ones,
// capturing the lowest on-set minterm and compressing the fn_out stream into a 16-bit MISR.
module qm_sweep_ctrl #(
  parameter int unsigned N_IN     = 11,
  parameter logic [15:0] SIG_POLY = 16'h1021
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            fn_out,
  output logic [N_IN-1:0] fn_in,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic [N_IN:0]   ones_count,
  output logic [N_IN-1:0] first_min,
  output logic            first_valid,
  output logic [15:0]     sig
);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] fn_in_q, fn_in_d;
  logic            aborted_q, aborted_d;
  logic [N_IN:0]   ones_q, ones_d;
  logic [N_IN-1:0] first_min_q, first_min_d;
  logic            first_valid_q, first_valid_d;
  logic [15:0]     sig_q, sig_d;
  logic            last_sample;

  assign last_sample = (fn_in_q == {N_IN{1'b1}});

  always_comb begin
    state_d       = state_q;
    fn_in_d       = fn_in_q;
    aborted_d     = aborted_q;
    ones_d        = ones_q;
    first_min_d   = first_min_q;
    first_valid_d = first_valid_q;
    sig_d         = sig_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        // abort beats start; a blocked start leaves every result untouched
        if (start && !abort) begin
          state_d       = StSweep;
          fn_in_d       = '0;
          ones_d        = '0;
          first_min_d   = '0;
          first_valid_d = 1'b0;
          sig_d         = 16'hFFFF;
          aborted_d     = 1'b0;
        end
      end
      StSweep: begin
        if (abort) begin
          // the sample on the abort edge is dropped; partial results freeze
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else begin
          ones_d = ones_q + {{N_IN{1'b0}}, fn_out};
          if (fn_out && !first_valid_q) begin
            first_min_d   = fn_in_q;
            first_valid_d = 1'b1;
          end
          sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? SIG_POLY : 16'h0000) ^ {15'b0, fn_out};
          if (last_sample) begin
            state_d = StDone;
          end else begin
            fn_in_d = fn_in_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      fn_in_q       <= '0;
      aborted_q     <= 1'b0;
      ones_q        <= '0;
      first_min_q   <= '0;
      first_valid_q <= 1'b0;
      sig_q         <= 16'hFFFF;
    end else begin
      state_q       <= state_d;
      fn_in_q       <= fn_in_d;
      aborted_q     <= aborted_d;
      ones_q        <= ones_d;
      first_min_q   <= first_min_d;
      first_valid_q <= first_valid_d;
      sig_q         <= sig_d;
    end
  end

  assign fn_in       = fn_in_q;
  assign busy        = (state_q == StSweep);
  assign done        = (state_q == StDone);
  assign aborted     = aborted_q;
  assign ones_count  = ones_q;
  assign first_min   = first_min_q;
  assign first_valid = first_valid_q;
  assign sig         = sig_q;

endmodule

// File: tb/tb_qm_sweep_ctrl.sv
// Bench for qm_sweep_ctrl: the swept function is a truth table held here, and every expected
// result is recomputed from that table by a whole-table reference model.
module tb_qm_sweep_ctrl;

  localparam int NIN   = 11;
  localparam int NMIN  = 1 << NIN;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic            fn_out;
  logic [NIN-1:0]  fn_in;
  logic            busy;
  logic            done;
  logic            aborted;
  logic [NIN:0]    ones_count;
  logic [NIN-1:0]  first_min;
  logic            first_valid;
  logic [15:0]     sig;

  qm_sweep_ctrl #(.N_IN(NIN), .SIG_POLY(16'h1021)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .fn_out      (fn_out),
    .fn_in       (fn_in),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .ones_count  (ones_count),
    .first_min   (first_min),
    .first_valid (first_valid),
    .sig         (sig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit tt [NMIN];
  always_comb fn_out = tt[fn_in];

  int checks = 0;
  int errors = 0;

  int          m_ones;
  int          m_first;
  bit          m_fv;
  logic [15:0] m_sig;

  typedef struct {
    int mode;        // 0 all-zero, 1 all-one, 2 minterms 5 and 1000, 3 random sparse
    int exp_ones;    // -1: take from the model
    int exp_first;
    int exp_fv;
    int restart_at;  // fn_in at which a stray start is pulsed, -1 for none
    bit chain;       // hold start at DONE to launch a back-to-back sweep
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_table(input int mode);
    for (int i = 0; i < NMIN; i++) begin
      case (mode)
        0:       tt[i] = 1'b0;
        1:       tt[i] = 1'b1;
        2:       tt[i] = (i == 5) || (i == 1000);
        default: tt[i] = ($urandom_range(0, 40) == 0);
      endcase
    end
  endtask

  // Whole-table results: population count, lowest on-set index, serial MISR over the table.
  task automatic model();
    logic [15:0] s;
    m_ones  = 0;
    m_first = 0;
    m_fv    = 1'b0;
    s       = 16'hFFFF;
    for (int i = 0; i < NMIN; i++) begin
      if (tt[i]) begin
        m_ones++;
        if (!m_fv) begin
          m_first = i;
          m_fv    = 1'b1;
        end
      end
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, tt[i]};
    end
    m_sig = s;
  endtask

  task automatic run_sweep(input string tag, input vec_t v);
    int n;
    bit seen;
    int e_ones, e_first, e_fv;
    fill_table(v.mode);
    model();
    e_ones  = (v.exp_ones  >= 0) ? v.exp_ones  : m_ones;
    e_first = (v.exp_first >= 0) ? v.exp_first : m_first;
    e_fv    = (v.exp_fv    >= 0) ? v.exp_fv    : int'(m_fv);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, " busy at accept"}, busy, 1);
    check({tag, " sig at accept"}, sig, 16'hFFFF);
    n    = 0;
    seen = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) n++;
      if (v.restart_at >= 0 && int'(fn_in) == v.restart_at) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    check({tag, " done seen"}, seen, 1);
    check({tag, " sweep cycles"}, n, NMIN);
    check({tag, " busy at done"}, busy, 0);
    check({tag, " ones_count"}, ones_count, e_ones);
    check({tag, " first_min"}, first_min, e_first);
    check({tag, " first_valid"}, first_valid, e_fv);
    check({tag, " sig"}, sig, m_sig);
    check({tag, " fn_in final"}, fn_in, NMIN - 1);
    check({tag, " aborted"}, aborted, 0);
    if (v.chain) begin
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check({tag, " chain busy"}, busy, 1);
      check({tag, " chain fn_in"}, fn_in, 0);
      check({tag, " chain ones"}, ones_count, 0);
      check({tag, " chain fv"}, first_valid, 0);
      check({tag, " chain sig"}, sig, 16'hFFFF);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check({tag, " chain aborted"}, aborted, 1);
      check({tag, " chain idle"}, busy, 0);
    end else begin
      @(posedge clk);
      #1;
      check({tag, " done one cycle"}, done, 0);
      check({tag, " idle after done"}, busy, 0);
      check({tag, " ones hold"}, ones_count, e_ones);
      check({tag, " sig hold"}, sig, m_sig);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " fn_in"}, fn_in, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " aborted"}, aborted, 0);
    check({tag, " ones"}, ones_count, 0);
    check({tag, " first_min"}, first_min, 0);
    check({tag, " first_valid"}, first_valid, 0);
    check({tag, " sig"}, sig, 16'hFFFF);
  endtask

  task automatic start_and_wait(input string tag, input int target);
    bit hit;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if (int'(fn_in) == target && busy) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, " reached target"}, hit, 1);
  endtask

  initial begin
    bit saw;
    vecs[0] = '{mode: 0, exp_ones: 0,    exp_first: 0,  exp_fv: 0,  restart_at: -1, chain: 0};
    vecs[1] = '{mode: 1, exp_ones: 2048, exp_first: 0,  exp_fv: 1,  restart_at: -1, chain: 0};
    vecs[2] = '{mode: 2, exp_ones: 2,    exp_first: 5,  exp_fv: 1,  restart_at: -1, chain: 0};
    vecs[3] = '{mode: 3, exp_ones: -1,   exp_first: -1, exp_fv: -1, restart_at: -1, chain: 0};
    vecs[4] = '{mode: 3, exp_ones: -1,   exp_first: -1, exp_fv: -1, restart_at: -1, chain: 1};
    vecs[5] = '{mode: 2, exp_ones: 2,    exp_first: 5,  exp_fv: 1,  restart_at: 10, chain: 0};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    fill_table(0);
    #23;
    check_reset_values("reset");

    // start presented with reset release is taken on the very first edge
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("first edge start", busy, 1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;

    for (int i = 0; i < 6; i++) run_sweep($sformatf("vec%0d", i), vecs[i]);

    // start together with abort while idle: nothing moves
    start = 1'b1;
    abort = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("start+abort busy", busy, 0);
    check("start+abort fn_in", fn_in, NMIN - 1);
    check("start+abort ones", ones_count, 2);
    check("start+abort aborted", aborted, 0);

    // abort at fn_in=100 with fn_out=1 everywhere
    fill_table(1);
    start_and_wait("abort", 100);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort flag", aborted, 1);
    check("abort ones", ones_count, 100);
    check("abort fn_in", fn_in, 100);
    check("abort first_min", first_min, 0);
    saw = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1 if (done || busy) saw = 1'b1;
    end
    check("abort quiet after", saw, 0);
    check("abort ones hold", ones_count, 100);

    // reset in the middle of a sweep
    start_and_wait("rst", 500);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1 if (done || busy) saw = 1'b1;
    end
    check("no done after reset", saw, 0);
    run_sweep("post reset", vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
